// File: rtl/pwm_bank_if.sv
// rtl/pwm_bank_if.sv - duty shadow-register write port
interface pwm_bank_if #(
  parameter int CHANNELS = 16,
  parameter int DUTY_W   = 8
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic              duty_we;
  logic [SEL_W-1:0]  duty_sel;
  logic [DUTY_W-1:0] duty_wdata;

  modport master (output duty_we, duty_sel, duty_wdata);
  modport slave  (input  duty_we, duty_sel, duty_wdata);
endinterface

// File: rtl/pwm_bank.sv
// rtl/pwm_bank.sv - multi-channel PWM with prescaler, edge/center counting and shadowed duties
module pwm_bank #(
  parameter int CHANNELS   = 16,
  parameter int DUTY_W     = 8,
  parameter int PRESCALE_W = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CHANNELS-1:0]   en_out,
  input  logic [CHANNELS-1:0]   en_pwm,
  pwm_bank_if.slave             wr,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  mode,
  output logic [CHANNELS-1:0]   pwm_out,
  output logic                  period_start
);
  localparam int SEL_W = $clog2(CHANNELS);
  localparam logic [DUTY_W-1:0] MAX = '1;
  localparam logic [DUTY_W-1:0] TOP = {{(DUTY_W-1){1'b1}}, 1'b0};

  logic [PRESCALE_W-1:0] pcnt;
  logic                  tick;
  logic [DUTY_W-1:0]     cnt;
  logic [DUTY_W-1:0]     cnt_nxt;
  logic                  dir;
  logic                  dir_nxt;
  logic                  load;
  logic                  mode_act;
  logic [DUTY_W-1:0]     duty_shadow [CHANNELS];
  logic [DUTY_W-1:0]     duty_act    [CHANNELS];
  logic [CHANNELS-1:0]   hit;
  logic [CHANNELS-1:0]   raw;

  // A prescale lowered below pcnt ticks at once instead of waiting for a wrap.
  assign tick = (pcnt >= prescale);

  always_comb begin
    cnt_nxt = cnt;
    dir_nxt = dir;
    load    = 1'b0;
    if (tick) begin
      if (!mode_act) begin
        if (cnt >= TOP) begin
          cnt_nxt = '0;
          load    = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end else if (dir) begin
        if (cnt >= TOP) begin
          cnt_nxt = cnt - 1'b1;
          dir_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end else begin
        if (cnt <= 1) begin
          cnt_nxt = '0;
          dir_nxt = 1'b1;
          load    = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
    end
  end

  always_comb begin
    hit = '0;
    raw = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      hit[i] = wr.duty_we && (wr.duty_sel == SEL_W'(i));
      raw[i] = (duty_act[i] == MAX) || (cnt < duty_act[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt         <= '0;
      cnt          <= '0;
      dir          <= 1'b1;
      mode_act     <= 1'b0;
      period_start <= 1'b0;
      pwm_out      <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_shadow[i] <= '0;
        duty_act[i]    <= '0;
      end
    end else begin
      pcnt         <= tick ? '0 : pcnt + 1'b1;
      cnt          <= cnt_nxt;
      dir          <= dir_nxt;
      period_start <= load;
      pwm_out      <= en_out & ((en_pwm & raw) | ~en_pwm);
      if (load) begin
        mode_act <= mode;
      end
      // A write landing on the load edge goes straight into the active duty.
      for (int i = 0; i < CHANNELS; i++) begin
        if (hit[i]) begin
          duty_shadow[i] <= wr.duty_wdata;
        end
        if (load) begin
          duty_act[i] <= hit[i] ? wr.duty_wdata : duty_shadow[i];
        end
      end
    end
  end
endmodule

// File: tb/tb_pwm_bank.sv
// tb/tb_pwm_bank.sv - table-driven self-checking bench for pwm_bank
module tb_pwm_bank;
  localparam int CH = 16;
  localparam int DW = 8;
  localparam int PW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] en_out;
  logic [CH-1:0] en_pwm;
  logic [PW-1:0] prescale;
  logic          mode;
  logic [CH-1:0] pwm_out;
  logic          period_start;

  pwm_bank_if #(.CHANNELS(CH), .DUTY_W(DW)) bus ();

  pwm_bank #(.CHANNELS(CH), .DUTY_W(DW), .PRESCALE_W(PW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_out       (en_out),
    .en_pwm       (en_pwm),
    .wr           (bus),
    .prescale     (prescale),
    .mode         (mode),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int pre;
    int md;
    int duty;
    int eo;
    int ep;
    int exp_high;
    int exp_len;
  } vec_t;

  vec_t vecs [10];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ps(input string name);
    int n = 0;
    while (!period_start && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({name, " period_start seen"}, int'(period_start), 1);
  endtask

  // Starts at a period_start negedge; samples the next full period of pwm_out[ch].
  // act: 1 = duty write of arg, 2 = mode <= arg, 3 = prescale <= arg, at index act_at.
  task automatic measure(input int ch, input int act_at, input int act, input int arg,
                         output int high, output int len);
    high = 0;
    len  = 0;
    do begin
      bus.duty_we = 1'b0;
      if (len == act_at) begin
        case (act)
          1: begin
            bus.duty_we    = 1'b1;
            bus.duty_sel   = 4'(ch);
            bus.duty_wdata = 8'(arg);
          end
          2: mode = arg[0];
          3: prescale = PW'(arg);
          default: ;
        endcase
      end
      @(negedge clk);
      len++;
      if (pwm_out[ch]) high++;
    end while (!period_start && len < 5000);
    bus.duty_we = 1'b0;
  endtask

  task automatic count_to_ps(output int n, output int any_high);
    n = 0;
    any_high = 0;
    while (!period_start && n < 1000) begin
      @(negedge clk);
      n++;
      if (pwm_out != '0) any_high++;
    end
  endtask

  initial begin
    int h;
    int l;
    int n;
    int ah;

    vecs[0] = '{3,  0, 0, 8'h80, 1, 1, 128, 255};
    vecs[1] = '{3,  0, 0, 8'h00, 1, 1,   0, 255};
    vecs[2] = '{3,  0, 0, 8'hFF, 1, 1, 255, 255};
    vecs[3] = '{5,  0, 0, 8'h40, 1, 0, 255, 255};
    vecs[4] = '{5,  0, 0, 8'hFF, 0, 1,   0, 255};
    vecs[5] = '{0,  0, 0, 8'h01, 1, 1,   1, 255};
    vecs[6] = '{7,  1, 0, 8'h10, 1, 1,  32, 510};
    vecs[7] = '{3,  3, 1, 8'h10, 1, 1, 124, 2032};
    vecs[8] = '{15, 0, 1, 8'hFE, 1, 1, 507, 508};
    vecs[9] = '{2,  0, 1, 8'h01, 1, 1,   1, 508};

    en_out = '0;
    en_pwm = '0;
    prescale = '0;
    mode = 1'b0;
    bus.duty_we = 1'b0;
    bus.duty_sel = '0;
    bus.duty_wdata = '0;

    repeat (3) @(negedge clk);
    check("reset pwm_out", int'(pwm_out), 0);
    check("reset period_start", int'(period_start), 0);

    en_out = '1;
    en_pwm = '1;
    rst_n = 1'b1;
    count_to_ps(n, ah);
    check("first period_start latency", n, 255);
    check("outputs low after reset", ah, 0);

    for (int i = 0; i < 10; i++) begin
      en_out = '0;
      en_pwm = '0;
      en_out[vecs[i].ch] = vecs[i].eo[0];
      en_pwm[vecs[i].ch] = vecs[i].ep[0];
      prescale = PW'(vecs[i].pre);
      mode = vecs[i].md[0];
      bus.duty_we = 1'b1;
      bus.duty_sel = 4'(vecs[i].ch);
      bus.duty_wdata = 8'(vecs[i].duty);
      @(negedge clk);
      bus.duty_we = 1'b0;
      wait_ps($sformatf("vec%0d", i));
      measure(vecs[i].ch, -1, 0, 0, h, l);
      check($sformatf("vec%0d high clocks", i), h, vecs[i].exp_high);
      check($sformatf("vec%0d period clocks", i), l, vecs[i].exp_len);
    end

    en_out = 16'h0001;
    en_pwm = 16'h0001;
    prescale = '0;
    mode = 1'b0;
    bus.duty_we = 1'b1;
    bus.duty_sel = 4'd0;
    bus.duty_wdata = 8'h40;
    @(negedge clk);
    bus.duty_we = 1'b0;
    wait_ps("shadow");
    measure(0, 100, 1, 8'hC0, h, l);
    check("shadow old duty kept", h, 64);
    check("shadow period", l, 255);
    measure(0, 254, 1, 8'h20, h, l);
    check("shadow new duty next period", h, 192);
    measure(0, -1, 0, 0, h, l);
    check("write-through at load", h, 32);

    prescale = 12'd3;
    @(negedge clk);
    wait_ps("prescale");
    measure(0, 3, 3, 1, h, l);
    check("prescale drop period", l, 512);
    check("prescale drop high", h, 66);
    measure(0, -1, 0, 0, h, l);
    check("prescale 1 period", l, 510);
    check("prescale 1 high", h, 64);

    measure(0, 100, 2, 1, h, l);
    check("mode toggle keeps edge period", l, 510);
    measure(0, -1, 0, 0, h, l);
    check("center period after switch", l, 1016);
    check("center high after switch", h, 126);
    measure(0, 100, 2, 0, h, l);
    check("mode toggle keeps center period", l, 1016);
    measure(0, -1, 0, 0, h, l);
    check("edge period after switch back", l, 510);

    prescale = '0;
    en_out = 16'h0008;
    en_pwm = 16'h0008;
    bus.duty_we = 1'b1;
    bus.duty_sel = 4'd3;
    bus.duty_wdata = 8'h80;
    @(negedge clk);
    bus.duty_we = 1'b0;
    wait_ps("pre-reset");
    repeat (10) @(negedge clk);
    check("pulse high before reset", int'(pwm_out[3]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset pwm_out", int'(pwm_out), 0);
    check("async reset period_start", int'(period_start), 0);
    @(negedge clk);
    rst_n = 1'b1;
    count_to_ps(n, ah);
    check("period_start after mid reset", n, 255);
    check("outputs low after mid reset", ah, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
